md_ctrl: RTL and testbench
==========================

# md_ctrl

Multiply/divide sequencer for the five-stage pipeline. It owns the HI/LO registers and a counter that models the latency of multi-cycle multiply/divide. It drives the stall that freezes the IF/ID register and PC and flushes ID/EX. It sits beside the E-stage ALU: E-stage feeds the operation and operands, and D-stage reports whether the instruction it holds touches HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- e_op  input  3  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- e_a  input  32  rs value (multiplicand/dividend/mthi/mtlo source)
- e_b  input  32  rt value (multiplier/divisor)
- d_uses_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  sequencer in RUN state
- stall  output  1  freeze PC and IF/ID, flush ID/EX
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Reset values: state IDLE, counter 0, busy 0, hi 0, lo 0.
- stall = d_uses_md & (busy | start). start = (state==IDLE) & e_op∈{1..4}. stall is combinational.
- States:
  - IDLE → RUN on start. At that edge: counter ← N−1 (N = MULT_CYCLES or DIV_CYCLES); result computed from e_a/e_b and latched into pend_hi/pend_lo; op latched.
  - RUN: counter decrements each edge. At the edge where counter==0: hi ← pend_hi, lo ← pend_lo, state → IDLE.
- mthi/mtlo in IDLE: hi (or lo) ← e_a at the next edge, no busy, no stall.
- Any e_op other than none while in RUN is a protocol violation. It is ignored, and hi/lo/counter are unaffected. The stall prevents it in legal pipelines.
- Arithmetic:
  - mult: signed 32×32→64. multu: unsigned 32×32→64. {hi,lo} = product.
  - div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (div or divu): still runs DIV_CYCLES; hi/lo keep their previous values at completion.
- Reset asserted mid-RUN: immediately IDLE, busy 0, hi/lo 0, and the pending result is discarded.

## Timing
- Op in E during cycle t (start=1): busy high in cycles t+1 … t+N, low at t+N+1.
- New hi/lo are visible from cycle t+N+1. mfhi reaching E at t+N+1 reads the new value.
- stall can be high in cycle t (start) and in each busy cycle, only while d_uses_md=1.
- mthi/mtlo in E at cycle t: value visible on hi/lo at cycle t+1.
- Back-to-back: an md op in D stalls until busy drops, then enters E at t+N+2 at the earliest.

## Structure
- Shared package md_pkg:
  - e_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - state encoding (S_IDLE, S_RUN)
  - counter width CNT_W = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1)
- One combinational sub-module md_core is natural: (op, a, b) → {hi, lo, div_by_zero}. md_ctrl holds the FSM, counter, pending result and HI/LO.

## Test plan
- mult e_a=3, e_b=0xFFFFFFFE (−2) → busy cycles t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA. The same operands with multu → hi=0x00000002, lo=0xFFFFFFFA.
- div e_a=0xFFFFFFF9 (−7), e_b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with e_a=7, e_b=2 → lo=3, hi=1.
- Edge division cases, with hi/lo preloaded 0x11111111/0x22222222:
  - div e_b=0 → busy 10 cycles, hi/lo unchanged.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Stall: multu at t with d_uses_md=1 from t → stall high t..t+5, low at t+6. With d_uses_md=0 throughout, stall stays 0 while busy=1.
- mthi e_a=0xDEADBEEF then mtlo e_a=0x12345678 on consecutive cycles → hi=0xDEADBEEF at t+1, lo=0x12345678 at t+2, busy never asserted.
- Reset: div started at t, reset driven low at t+4 → busy, hi, lo drop to 0 without waiting for the edge. After release, everything stays idle with hi=lo=0 and no late completion.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide sequencer.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Counter must hold the largest reload value (N-1) and the value N itself.
    function automatic int md_cnt_w(input int mult_cycles, input int div_cycles);
        return $clog2(((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1);
    endfunction

    localparam int CNT_W = md_cnt_w(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/md_if.sv
// E/D-stage to multiply/divide sequencer bundle; the sequencer is the slave side.
interface md_if;
    import md_pkg::*;

    md_op_e      e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_uses_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_e   state;

    // Pipeline side: drives the operation every cycle; consumes stall and hi/lo.
    // There is no handshake: while busy, any op other than none is ignored, and
    // stall (combinational) keeps a legal pipeline from ever issuing one.
    modport master (
        output e_op, e_a, e_b, d_uses_md,
        input  busy, stall, hi, lo, state
    );

    modport slave (
        input  e_op, e_a, e_b, d_uses_md,
        output busy, stall, hi, lo, state
    );

endinterface

// File: rtl/md_core.sv
// Combinational multiply/divide datapath producing the {hi,lo} result for one op.
module md_core
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic        is_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign a_ext     = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign b_ext     = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign prod      = a_ext * b_ext;

    // Signed division on magnitudes: the 0x80000000 / -1 case falls out as
    // 0x80000000 with remainder 0 without a special path.
    assign neg_a  = is_signed & a[31];
    assign neg_b  = is_signed & b[31];
    assign mag_a  = neg_a ? (~a + 32'd1) : a;
    assign mag_b  = neg_b ? (~b + 32'd1) : b;
    assign safe_b = (b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag  = mag_a / safe_b;
    assign r_mag  = mag_a % safe_b;
    assign quo    = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = neg_a ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        hi          = 32'd0;
        lo          = 32'd0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                hi = prod[63:32];
                lo = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                hi          = rem;
                lo          = quo;
                div_by_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: HI/LO ownership, latency counter and pipeline stall.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    localparam int              LCL_CNT_W = md_cnt_w(MULT_CYCLES, DIV_CYCLES);
    localparam logic [LCL_CNT_W-1:0] MULT_LOAD = LCL_CNT_W'(MULT_CYCLES - 1);
    localparam logic [LCL_CNT_W-1:0] DIV_LOAD  = LCL_CNT_W'(DIV_CYCLES - 1);

    md_state_e            state_q, state_d;
    logic [LCL_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    logic [31:0]          pend_hi, pend_lo;
    logic                 pend_dz;
    logic [31:0]          core_hi, core_lo;
    logic                 core_dz;
    logic                 is_md_op;
    logic                 start;

    md_core u_core (
        .op          (md.e_op),
        .a           (md.e_a),
        .b           (md.e_b),
        .hi          (core_hi),
        .lo          (core_lo),
        .div_by_zero (core_dz)
    );

    assign is_md_op = (md.e_op == MD_MULT) || (md.e_op == MD_MULTU) ||
                      (md.e_op == MD_DIV)  || (md.e_op == MD_DIVU);
    assign start    = (state_q == S_IDLE) && is_md_op;

    assign md.busy  = (state_q == S_RUN);
    assign md.stall = md.d_uses_md & (md.busy | start);
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = ((md.e_op == MD_MULT) || (md.e_op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
                end else if (md.e_op == MD_MTHI) begin
                    hi_d = md.e_a;
                end else if (md.e_op == MD_MTLO) begin
                    lo_d = md.e_a;
                end
            end
            S_RUN: begin
                // Ops arriving here are protocol violations and are dropped.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (!pend_dz) begin
                        hi_d = pend_hi;
                        lo_d = pend_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (start) begin
                pend_hi <= core_hi;
                pend_lo <= core_lo;
                pend_dz <= core_dz;
            end
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vectors, corner sequences and random ops.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic        d_use;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    always #5 clk = ~clk;

    md_if bus ();

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour straight from the arithmetic rules.
    function automatic logic [63:0] model(input md_op_e op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] cur_hi,
                                          input logic [31:0] cur_lo);
        int          sa, sb, q, r;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            MD_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            MD_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            MD_DIV: begin
                if (b == 32'd0) return {cur_hi, cur_lo};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {cur_hi, cur_lo};
                return {a % b, a / b};
            end
            MD_MTHI: return {a, cur_lo};
            MD_MTLO: return {cur_hi, a};
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    // Issue one op in the current cycle and follow it to completion, checking
    // stall/busy each cycle and the {hi,lo} result against the scoreboard.
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic d_use);
        logic        is_md;
        int          n;
        logic [63:0] exp;
        is_md = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        n     = ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_N : DIV_N;
        bus.e_op      = op;
        bus.e_a       = a;
        bus.e_b       = b;
        bus.d_uses_md = d_use;
        #1;
        check("stall_start", 64'(bus.stall), 64'(d_use & is_md));
        step();
        bus.e_op = MD_NONE;
        if (is_md) begin
            for (int k = 1; k <= n; k++) begin
                check("busy_run", 64'(bus.busy), 64'd1);
                check("stall_run", 64'(bus.stall), 64'(d_use));
                step();
            end
        end
        check("busy_done", 64'(bus.busy), 64'd0);
        check("stall_done", 64'(bus.stall), 64'd0);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            exp = exp_q.pop_front();
            check("hilo", {bus.hi, bus.lo}, exp);
        end
        bus.d_uses_md = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        md_op_e      op;
        logic [31:0] a, b;
        logic [63:0] exp;

        vecs[0] = '{MD_MULT,  32'd3,          32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{MD_MULTU, 32'd3,          32'hFFFF_FFFE, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd7,          32'd2,         1'b0, 32'd1,         32'd3};
        vecs[4] = '{MD_MTHI,  32'h1111_1111,  32'd0,         1'b1, 32'h1111_1111, 32'd3};
        vecs[5] = '{MD_MTLO,  32'h2222_2222,  32'd0,         1'b1, 32'h1111_1111, 32'h2222_2222};
        vecs[6] = '{MD_DIV,   32'd1234,       32'd0,         1'b1, 32'h1111_1111, 32'h2222_2222};
        vecs[7] = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000};
        vecs[8] = '{MD_DIVU,  32'h5555_5555,  32'd0,         1'b0, 32'd0,         32'h8000_0000};
        vecs[9] = '{MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};

        // Clock/reset
        reset         = 1'b0;
        bus.e_op      = MD_NONE;
        bus.e_a       = 32'd0;
        bus.e_b       = 32'd0;
        bus.d_uses_md = 1'b0;
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_state", 64'(bus.state), 64'(S_IDLE));
        repeat (3) step();
        reset    = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        step();

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d_use);
            model_hi = vecs[i].exp_hi;
            model_lo = vecs[i].exp_lo;
        end

        // mthi then mtlo on consecutive cycles with D-stage using HI/LO
        bus.d_uses_md = 1'b1;
        bus.e_op = MD_MTHI;
        bus.e_a  = 32'hDEAD_BEEF;
        #1;
        check("mt_stall", 64'(bus.stall), 64'd0);
        step();
        check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        bus.e_op = MD_MTLO;
        bus.e_a  = 32'h1234_5678;
        step();
        bus.e_op = MD_NONE;
        check("mtlo_hilo", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'h1234_5678});
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        bus.d_uses_md = 1'b0;
        model_hi = 32'hDEAD_BEEF;
        model_lo = 32'h1234_5678;

        // Op issued while running is ignored
        bus.e_op = MD_MULT;
        bus.e_a  = 32'd5;
        bus.e_b  = 32'd7;
        step();
        bus.e_op = MD_MTHI;
        bus.e_a  = 32'hFFFF_FFFF;
        step();
        bus.e_op = MD_DIVU;
        step();
        bus.e_op = MD_NONE;
        repeat (MULT_N - 2) step();
        check("ignored_busy", 64'(bus.busy), 64'd0);
        check("ignored_hilo", {bus.hi, bus.lo}, {32'd0, 32'd35});
        step();
        check("ignored_idle", 64'(bus.busy), 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd35;

        // Reset asserted mid-run
        bus.e_op = MD_MTHI;
        bus.e_a  = 32'hAAAA_5555;
        step();
        bus.e_op = MD_DIV;
        bus.e_a  = 32'd100;
        bus.e_b  = 32'd3;
        step();
        bus.e_op = MD_NONE;
        repeat (3) step();
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_busy", 64'(bus.busy), 64'd0);
        check("async_hilo", {bus.hi, bus.lo}, 64'd0);
        check("async_state", 64'(bus.state), 64'(S_IDLE));
        step();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < DIV_N + 4; k++) begin
            step();
            check("post_reset_busy", 64'(bus.busy), 64'd0);
            check("post_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        end
        model_hi = 32'd0;
        model_lo = 32'd0;

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = md_op_e'($urandom_range(1, 6));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 9);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            exp = model(op, a, b, model_hi, model_lo);
            exp_q.push_back(exp);
            run_op(op, a, b, 1'($urandom_range(0, 1)));
            model_hi = exp[63:32];
            model_lo = exp[31:0];
            if ($urandom_range(0, 4) == 0) begin
                bus.e_op = MD_RSVD;
                bus.e_a  = $urandom;
                bus.d_uses_md = 1'b1;
                #1;
                check("rsvd_stall", 64'(bus.stall), 64'd0);
                step();
                bus.e_op = MD_NONE;
                bus.d_uses_md = 1'b0;
                check("rsvd_busy", 64'(bus.busy), 64'd0);
                check("rsvd_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});
            end
            repeat ($urandom_range(0, 2)) step();
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
